// File: rtl/gpio_debounce.sv
// Per-bit GPIO input conditioner: 2-flop synchronizer, tick-based debounce
// with per-bit bypass, registered edge pulses and sticky edge-event flags.
module gpio_debounce #(
  parameter int WIDTH        = 24,
  parameter int PRESCALE     = 1000,
  parameter int STABLE_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gp_in,
  input  logic [WIDTH-1:0] debounce_en,
  input  logic [WIDTH-1:0] evt_clr,
  output logic [WIDTH-1:0] gp_in_db,
  output logic [WIDTH-1:0] gp_rise,
  output logic [WIDTH-1:0] gp_fall,
  output logic [WIDTH-1:0] gp_evt
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic [3:0]  CNT_LAST   = 4'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]      sync1_q, sync1_d;
  logic [WIDTH-1:0]      sync2_q, sync2_d;
  logic [WIDTH-1:0]      stable_q, stable_d;
  logic [WIDTH-1:0][3:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      rise_q, rise_d;
  logic [WIDTH-1:0]      fall_q, fall_d;
  logic [WIDTH-1:0]      evt_q, evt_d;
  logic [15:0]           presc_q, presc_d;
  logic                  tick;

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    sync1_d  = gp_in;
    sync2_d  = sync1_q;
    presc_d  = tick ? 16'd0 : presc_q + 16'd1;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (!debounce_en[i]) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = 4'd0;
      end else if (sync2_q[i] == stable_q[i]) begin
        // Any return to the stable value restarts qualification.
        cnt_d[i] = 4'd0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
    rise_d = stable_d & ~stable_q;
    fall_d = ~stable_d & stable_q;
    // A pending edge pulse overrides a simultaneous clear.
    evt_d  = (evt_q & ~evt_clr) | rise_q | fall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      evt_q    <= '0;
      presc_q  <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      evt_q    <= evt_d;
      presc_q  <= presc_d;
    end
  end

  assign gp_in_db = stable_q;
  assign gp_rise  = rise_q;
  assign gp_fall  = fall_q;
  assign gp_evt   = evt_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce (PRESCALE=4, STABLE_TICKS=3): ticks act on
// edges 4, 8, 12, ... counted from reset release.
module tb_gpio_debounce;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] gp_in = '0;
  logic [W-1:0] debounce_en = '0;
  logic [W-1:0] evt_clr = '0;
  logic [W-1:0] gp_in_db, gp_rise, gp_fall, gp_evt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  gpio_debounce #(.WIDTH(W), .PRESCALE(4), .STABLE_TICKS(3)) dut (
    .clk(clk), .rst(rst), .gp_in(gp_in), .debounce_en(debounce_en),
    .evt_clr(evt_clr), .gp_in_db(gp_in_db), .gp_rise(gp_rise),
    .gp_fall(gp_fall), .gp_evt(gp_evt)
  );

  always #5 clk = ~clk;

  task automatic reset_dut(input logic [W-1:0] in_v, input logic [W-1:0] en_v);
    rst = 1'b1;
    gp_in = in_v;
    debounce_en = en_v;
    evt_clr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // All bits high in bypass while in reset: outputs stay 0, then rise after release.
  task automatic test_reset;
    rst = 1'b1;
    gp_in = '1;
    debounce_en = '0;
    evt_clr = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({gp_in_db, gp_rise, gp_fall, gp_evt} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got db=%h rise=%h fall=%h evt=%h expected all 0",
               gp_in_db, gp_rise, gp_fall, gp_evt);
    end
    rst = 1'b0;
    cyc = 0;
    step(2);
    vectors++;
    if (gp_in_db !== 24'h000000) begin
      miscompares++;
      $display("[TB] FAIL reset_sync_latency: got %h expected %h", gp_in_db, 24'h000000);
    end
    step(1);
    vectors++;
    if (gp_in_db !== 24'hFFFFFF || gp_rise !== 24'hFFFFFF || gp_fall !== 24'h000000) begin
      miscompares++;
      $display("[TB] FAIL reset_release_rise: got db=%h rise=%h fall=%h expected FFFFFF FFFFFF 000000",
               gp_in_db, gp_rise, gp_fall);
    end
    step(1);
    vectors++;
    if (gp_rise !== 24'h000000 || gp_evt !== 24'hFFFFFF) begin
      miscompares++;
      $display("[TB] FAIL reset_release_evt: got rise=%h evt=%h expected 000000 FFFFFF",
               gp_rise, gp_evt);
    end
  endtask

  task automatic test_bypass;
    reset_dut('0, '0);
    step(3);
    gp_in[0] = 1'b1;
    step(2);
    vectors++;
    if (gp_in_db !== 24'h000000) begin
      miscompares++;
      $display("[TB] FAIL bypass_early: got %h expected %h", gp_in_db, 24'h000000);
    end
    step(1);
    vectors++;
    if (gp_in_db !== 24'h000001 || gp_rise !== 24'h000001 || gp_fall !== 24'h000000) begin
      miscompares++;
      $display("[TB] FAIL bypass_rise: got db=%h rise=%h fall=%h expected 000001 000001 000000",
               gp_in_db, gp_rise, gp_fall);
    end
    step(1);
    vectors++;
    if (gp_rise !== 24'h000000 || gp_evt !== 24'h000001) begin
      miscompares++;
      $display("[TB] FAIL bypass_pulse_end: got rise=%h evt=%h expected 000000 000001", gp_rise, gp_evt);
    end
    step(5);
    vectors++;
    if (gp_evt !== 24'h000001 || gp_in_db !== 24'h000001) begin
      miscompares++;
      $display("[TB] FAIL bypass_sticky: got evt=%h db=%h expected 000001 000001", gp_evt, gp_in_db);
    end
  endtask

  task automatic test_debounce_accept;
    reset_dut(24'h000020, 24'h000020);
    step(11);
    vectors++;
    if (gp_in_db !== 24'h000000 || gp_rise !== 24'h000000) begin
      miscompares++;
      $display("[TB] FAIL deb_before_accept: got db=%h rise=%h expected 000000 000000", gp_in_db, gp_rise);
    end
    step(1);
    vectors++;
    if (gp_in_db !== 24'h000020 || gp_rise !== 24'h000020) begin
      miscompares++;
      $display("[TB] FAIL deb_accept: got db=%h rise=%h expected 000020 000020", gp_in_db, gp_rise);
    end
    step(1);
    vectors++;
    if (gp_rise !== 24'h000000 || gp_evt !== 24'h000020) begin
      miscompares++;
      $display("[TB] FAIL deb_single_pulse: got rise=%h evt=%h expected 000000 000020", gp_rise, gp_evt);
    end
    gp_in[5] = 1'b0;
    step(10);
    vectors++;
    if (gp_in_db !== 24'h000020 || gp_fall !== 24'h000000) begin
      miscompares++;
      $display("[TB] FAIL deb_before_fall: got db=%h fall=%h expected 000020 000000", gp_in_db, gp_fall);
    end
    step(1);
    vectors++;
    if (gp_in_db !== 24'h000000 || gp_fall !== 24'h000020 || gp_rise !== 24'h000000) begin
      miscompares++;
      $display("[TB] FAIL deb_fall: got db=%h fall=%h rise=%h expected 000000 000020 000000",
               gp_in_db, gp_fall, gp_rise);
    end
  endtask

  // Each glitch spans exactly one tick edge, so the count never gets past 1.
  task automatic test_glitch;
    reset_dut('0, 24'h000020);
    for (int g = 0; g < 20; g++) begin
      gp_in[5] = 1'b1;
      for (int c = 0; c < 12; c++) begin
        if (c == 4) gp_in[5] = 1'b0;
        step(1);
        vectors++;
        if ({gp_in_db[5], gp_rise[5], gp_fall[5], gp_evt[5]} !== 4'b0000) begin
          miscompares++;
          $display("[TB] FAIL glitch_%0d_%0d: got db/rise/fall/evt=%b expected 0000",
                   g, c, {gp_in_db[5], gp_rise[5], gp_fall[5], gp_evt[5]});
        end
      end
    end
  endtask

  task automatic test_evt_clr;
    reset_dut('0, '0);
    step(2);
    gp_in[2] = 1'b1;
    step(6);
    vectors++;
    if (gp_in_db !== 24'h000004 || gp_evt !== 24'h000004) begin
      miscompares++;
      $display("[TB] FAIL clr_setup: got db=%h evt=%h expected 000004 000004", gp_in_db, gp_evt);
    end
    gp_in[2] = 1'b0;
    step(3);
    vectors++;
    if (gp_fall !== 24'h000004) begin
      miscompares++;
      $display("[TB] FAIL clr_fall: got %h expected %h", gp_fall, 24'h000004);
    end
    evt_clr[2] = 1'b1;
    step(1);
    vectors++;
    if (gp_evt !== 24'h000004 || gp_fall !== 24'h000000) begin
      miscompares++;
      $display("[TB] FAIL clr_set_wins: got evt=%h fall=%h expected 000004 000000", gp_evt, gp_fall);
    end
    step(1);
    evt_clr[2] = 1'b0;
    vectors++;
    if (gp_evt !== 24'h000000) begin
      miscompares++;
      $display("[TB] FAIL clr_clears: got %h expected %h", gp_evt, 24'h000000);
    end
    step(2);
    vectors++;
    if (gp_evt !== 24'h000000) begin
      miscompares++;
      $display("[TB] FAIL clr_stays: got %h expected %h", gp_evt, 24'h000000);
    end
  endtask

  task automatic test_reset_mid;
    reset_dut(24'h000081, 24'h000080);
    step(9);
    vectors++;
    if (gp_in_db !== 24'h000001 || gp_evt !== 24'h000001) begin
      miscompares++;
      $display("[TB] FAIL mid_setup: got db=%h evt=%h expected 000001 000001", gp_in_db, gp_evt);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({gp_in_db, gp_rise, gp_fall, gp_evt} !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid_async_clear: got db=%h rise=%h fall=%h evt=%h expected all 0",
               gp_in_db, gp_rise, gp_fall, gp_evt);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    step(11);
    vectors++;
    if (gp_in_db[7] !== 1'b0 || gp_rise[7] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_no_early: got db7=%b rise7=%b expected 0 0", gp_in_db[7], gp_rise[7]);
    end
    step(1);
    vectors++;
    if (gp_in_db[7] !== 1'b1 || gp_rise[7] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_full_requal: got db7=%b rise7=%b expected 1 1", gp_in_db[7], gp_rise[7]);
    end
  endtask

  task automatic test_mode_switch;
    reset_dut(24'h000008, 24'h000008);
    step(9);
    vectors++;
    if (gp_in_db[3] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mode_pending: got %b expected 0", gp_in_db[3]);
    end
    debounce_en[3] = 1'b0;
    step(1);
    vectors++;
    if (gp_in_db[3] !== 1'b1 || gp_rise[3] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mode_bypass_take: got db3=%b rise3=%b expected 1 1", gp_in_db[3], gp_rise[3]);
    end
    debounce_en[3] = 1'b1;
    gp_in[3] = 1'b0;
    step(13);
    vectors++;
    if (gp_in_db[3] !== 1'b1 || gp_fall[3] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mode_requal_wait: got db3=%b fall3=%b expected 1 0", gp_in_db[3], gp_fall[3]);
    end
    step(1);
    vectors++;
    if (gp_in_db[3] !== 1'b0 || gp_fall[3] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mode_requal_fall: got db3=%b fall3=%b expected 0 1", gp_in_db[3], gp_fall[3]);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] en_r, m_s1, m_s2, m_st, m_rise, m_fall, m_evt, n_st;
    int           m_cnt [W];
    int           hold [W];
    en_r = W'($urandom);
    reset_dut('0, en_r);
    m_s1 = '0; m_s2 = '0; m_st = '0; m_rise = '0; m_fall = '0; m_evt = '0;
    for (int i = 0; i < W; i++) begin
      m_cnt[i] = 0;
      hold[i] = int'($urandom_range(1, 18));
    end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          gp_in[i] = ~gp_in[i];
          hold[i] = int'($urandom_range(1, 18));
        end else begin
          hold[i]--;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      n_st = m_st;
      for (int i = 0; i < W; i++) begin
        if (!en_r[i]) begin
          n_st[i] = m_s2[i];
          m_cnt[i] = 0;
        end else if (m_s2[i] == m_st[i]) begin
          m_cnt[i] = 0;
        end else if (cyc % 4 == 0) begin
          m_cnt[i]++;
          if (m_cnt[i] == 3) begin
            n_st[i] = m_s2[i];
            m_cnt[i] = 0;
          end
        end
      end
      m_evt  = m_evt | m_rise | m_fall;
      m_rise = n_st & ~m_st;
      m_fall = m_st & ~n_st;
      m_st   = n_st;
      m_s2   = m_s1;
      m_s1   = gp_in;
      vectors++;
      if (gp_in_db !== m_st) begin
        miscompares++;
        $display("[TB] FAIL rand_db cyc %0d: got %h expected %h", cyc, gp_in_db, m_st);
      end
      vectors++;
      if (gp_rise !== m_rise) begin
        miscompares++;
        $display("[TB] FAIL rand_rise cyc %0d: got %h expected %h", cyc, gp_rise, m_rise);
      end
      vectors++;
      if (gp_fall !== m_fall) begin
        miscompares++;
        $display("[TB] FAIL rand_fall cyc %0d: got %h expected %h", cyc, gp_fall, m_fall);
      end
      vectors++;
      if (gp_evt !== m_evt) begin
        miscompares++;
        $display("[TB] FAIL rand_evt cyc %0d: got %h expected %h", cyc, gp_evt, m_evt);
      end
      vectors++;
      if ((gp_rise & gp_fall) !== '0) begin
        miscompares++;
        $display("[TB] FAIL rand_rise_and_fall cyc %0d: got %h expected %h", cyc, gp_rise & gp_fall, 24'h0);
      end
    end
  endtask

  initial begin
    $display("[TB] gpio_debounce directed tests starting");
    test_reset();
    test_bypass();
    test_debounce_accept();
    test_glitch();
    test_evt_clr();
    test_reset_mid();
    test_mode_switch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
